regfile_wb_sink: RTL and testbench
==================================

Name: regfile_wb_sink

Overview:
- Architectural integer register file that consumes the registered writeback outputs (Result, RegWrite, Rd) of the pipeline.
- Serves the decode stage through two asynchronous read ports.
- Holds a pending-write scoreboard: decode marks destination registers as in flight, and writeback clears them.
- Sits between the writeback stage and the decode/hazard logic.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register index width; the file holds 2**ADDR_W entries, and entry 0 is hardwired to zero.

Ports:
- clk  input  1  clock, all state updates on posedge.
- rst  input  1  reset, asynchronous, active-high.
- RegWrite  input  1  writeback write enable.
- Rd  input  ADDR_W  writeback destination index.
- Result  input  DATA_W  writeback data.
- A1  input  ADDR_W  read port 1 index.
- A2  input  ADDR_W  read port 2 index.
- RD1  output  DATA_W  read port 1 data.
- RD2  output  DATA_W  read port 2 data.
- IssueValid  input  1  decode issues an instruction that will write IssueRd.
- IssueRd  input  ADDR_W  destination index being issued.
- Flush  input  1  pipeline flush; clears all pending bits.
- Busy1  output  1  register A1 has a write in flight.
- Busy2  output  1  register A2 has a write in flight.
- PendCount  output  ADDR_W+1  number of pending bits currently set.

Behaviour:
- Reset: rst=1 asynchronously clears every register entry and every pending bit.
  - Consequently RD1=RD2=0, Busy1=Busy2=0, PendCount=0 while rst is held and immediately after release.
- Write: on posedge clk with RegWrite=1 and Rd!=0, mem[Rd] <= Result.
  - A write with Rd=0 is discarded.
  - Write latency is 1 cycle: the value is visible through the array from the next cycle.
- Read: combinational.
  - RDn = 0 if An==0, else mem[An] (subject to the bypass option).
  - A1 and A2 may be equal; both ports return identical data.
- Scoreboard: one pending bit per entry 1..2**ADDR_W-1; bit 0 is constant 0.
  - Set: posedge with IssueValid=1 and IssueRd!=0 sets pend[IssueRd].
  - Clear: posedge with RegWrite=1 and Rd!=0 clears pend[Rd].
  - Same register set and cleared in one cycle: set wins, because the issue is younger than the completing write.
  - Set and clear on different registers in the same cycle: both take effect.
  - Setting an already-set bit leaves it set; there is no count of multiple outstanding writes.
  - Flush=1 at posedge clears all pending bits, then applies the set from IssueValid in the same cycle.
    - IssueValid is normally 0 during Flush; if it is 1, its set applies.
  - Flush has priority over the writeback clear, which is redundant anyway.
- Busy outputs: Busyn = pend[An], with An==0 giving 0.
  - Busyn is masked to 0 when the bypass option is enabled and a matching writeback is active this cycle.
- PendCount: registered population count of the pending bits, updated in the same edge as the bits and consistent with them every cycle.
- Reset mid-operation: any in-flight write or issue in the reset cycle is lost; the file and scoreboard come out all zero.

Optional Feature:
- Macro: RF_WB_BYPASS_EN.
- Defined (write-through bypass):
  - If RegWrite=1, Rd!=0 and Rd==An, then RDn = Result in the same cycle and Busyn=0.
  - This absorbs the extra register stage in writeback.
- Undefined:
  - RDn always returns the array contents, i.e. the old value until the next cycle.
  - Busyn reflects the pending bit only.
  - The hazard unit must stall one additional cycle.

Test Plan:
- Reset, then read all indices.
  - Expected: RD1=RD2=0, Busy=0 and PendCount=0 for every index.
- Write 0xDEADBEEF to x5, then read A1=5 the next cycle.
  - Expected: RD1=0xDEADBEEF.
  - In the write cycle itself: RD1=0xDEADBEEF with RF_WB_BYPASS_EN defined, 0 without it.
- Write 0x12345678 to x0, then read A1=A2=0.
  - Expected: RD1=RD2=0, and PendCount is unaffected.
- Issue x7, then x9, then a writeback to x7.
  - Expected: after the issues Busy(7)=1, Busy(9)=1, PendCount=2.
  - After the writeback: Busy(7)=0, PendCount=1.
- Issue x3 and write back x3 in the same cycle.
  - Expected: pend[3]=1 afterward and PendCount increments by 1.
- Set pend on x1, x2 and x4, then assert Flush with IssueValid=1 and IssueRd=6.
  - Expected: only pend[6]=1, PendCount=1.
  - Asserting rst mid-sequence instead gives PendCount=0 and all registers zero asynchronously.

Source files
------------

// File: rtl/regfile_wb_sink.sv
// rtl/regfile_wb_sink.sv - architectural register file with writeback sink, two async read ports and pending-write scoreboard
// Optional write-through bypass from writeback to the read ports: define RF_WB_BYPASS_EN.
module regfile_wb_sink #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] Rd,
    input  logic [DATA_W-1:0] Result,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    input  logic              IssueValid,
    input  logic [ADDR_W-1:0] IssueRd,
    input  logic              Flush,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   PendCount
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [0:NREG-1];
    logic [NREG-1:0]   r_pend;
    logic [ADDR_W:0]   r_pend_cnt;

    logic              w_wb_en;
    logic              w_issue_en;
    logic [NREG-1:0]   w_pend_next;
    logic              w_a1_zero;
    logic              w_a2_zero;
    logic              w_hit1;
    logic              w_hit2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_busy1;
    logic              w_busy2;

    function automatic logic [ADDR_W:0] f_popcount(input logic [NREG-1:0] v);
        logic [ADDR_W:0] c;
        c = '0;
        for (int i = 0; i < NREG; i++) begin
            c = c + {{ADDR_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    assign w_wb_en    = RegWrite && (Rd != '0);
    assign w_issue_en = IssueValid && (IssueRd != '0);
    assign w_a1_zero  = (A1 == '0);
    assign w_a2_zero  = (A2 == '0);

    // Entry 0 is kept in the array for uniform indexing but is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wb_en) begin
            r_mem[Rd] <= Result;
        end
    end

    // Flush beats the writeback clear; a younger issue beats both.
    always_comb begin
        w_pend_next = r_pend;
        if (Flush) begin
            w_pend_next = '0;
        end else if (w_wb_en) begin
            w_pend_next[Rd] = 1'b0;
        end
        if (w_issue_en) begin
            w_pend_next[IssueRd] = 1'b1;
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_pend     <= w_pend_next;
            r_pend_cnt <= f_popcount(w_pend_next);
        end
    end

`ifdef RF_WB_BYPASS_EN
    assign w_hit1 = w_wb_en && (Rd == A1);
    assign w_hit2 = w_wb_en && (Rd == A2);
`else
    assign w_hit1 = 1'b0;
    assign w_hit2 = 1'b0;
`endif

    always_comb begin
        w_rd1 = '0;
        w_rd2 = '0;
        if (w_a1_zero) begin
            w_rd1 = '0;
        end else if (w_hit1) begin
            w_rd1 = Result;
        end else begin
            w_rd1 = r_mem[A1];
        end
        if (w_a2_zero) begin
            w_rd2 = '0;
        end else if (w_hit2) begin
            w_rd2 = Result;
        end else begin
            w_rd2 = r_mem[A2];
        end
    end

    assign w_busy1 = !w_a1_zero && !w_hit1 && r_pend[A1];
    assign w_busy2 = !w_a2_zero && !w_hit2 && r_pend[A2];

    assign RD1       = w_rd1;
    assign RD2       = w_rd2;
    assign Busy1     = w_busy1;
    assign Busy2     = w_busy2;
    assign PendCount = r_pend_cnt;

endmodule

// File: tb/tb_regfile_wb_sink.sv
// tb/tb_regfile_wb_sink.sv - directed self-checking bench for regfile_wb_sink
module tb_regfile_wb_sink;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

`ifdef RF_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk;
    logic              rst;
    logic              RegWrite;
    logic [ADDR_W-1:0] Rd;
    logic [DATA_W-1:0] Result;
    logic [ADDR_W-1:0] A1;
    logic [ADDR_W-1:0] A2;
    logic [DATA_W-1:0] RD1;
    logic [DATA_W-1:0] RD2;
    logic              IssueValid;
    logic [ADDR_W-1:0] IssueRd;
    logic              Flush;
    logic              Busy1;
    logic              Busy2;
    logic [ADDR_W:0]   PendCount;

    int n_checks;
    int n_errors;

    regfile_wb_sink #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .RegWrite   (RegWrite),
        .Rd         (Rd),
        .Result     (Result),
        .A1         (A1),
        .A2         (A2),
        .RD1        (RD1),
        .RD2        (RD2),
        .IssueValid (IssueValid),
        .IssueRd    (IssueRd),
        .Flush      (Flush),
        .Busy1      (Busy1),
        .Busy2      (Busy2),
        .PendCount  (PendCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        RegWrite   = 1'b0;
        Rd         = '0;
        Result     = '0;
        A1         = '0;
        A2         = '0;
        IssueValid = 1'b0;
        IssueRd    = '0;
        Flush      = 1'b0;
        #2;

        for (int i = 0; i < 32; i++) begin
            A1 = ADDR_W'(i);
            A2 = ADDR_W'(31 - i);
            #1;
            check($sformatf("rst_rd1_%0d", i), RD1, 32'h0);
            check($sformatf("rst_rd2_%0d", i), RD2, 32'h0);
            check($sformatf("rst_busy1_%0d", i), {31'b0, Busy1}, 32'h0);
            check($sformatf("rst_busy2_%0d", i), {31'b0, Busy2}, 32'h0);
        end
        check("rst_pendcount", {26'b0, PendCount}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_pendcount", {26'b0, PendCount}, 32'h0);

        // Write x5
        RegWrite = 1'b1; Rd = 5'd5; Result = 32'hDEADBEEF; A1 = 5'd5; A2 = 5'd0;
        #1;
        check("wr5_same_cycle", RD1, BYPASS ? 32'hDEADBEEF : 32'h0);
        step;
        RegWrite = 1'b0;
        #1;
        check("wr5_next_cycle", RD1, 32'hDEADBEEF);

        // Write x0 is discarded
        RegWrite = 1'b1; Rd = 5'd0; Result = 32'h12345678; A1 = 5'd0; A2 = 5'd0;
        #1;
        check("wr0_same_rd1", RD1, 32'h0);
        step;
        RegWrite = 1'b0;
        #1;
        check("wr0_rd1", RD1, 32'h0);
        check("wr0_rd2", RD2, 32'h0);
        check("wr0_pendcount", {26'b0, PendCount}, 32'h0);

        // Issue to x0 is ignored
        IssueValid = 1'b1; IssueRd = 5'd0;
        step;
        IssueValid = 1'b0;
        #1;
        check("iss0_pendcount", {26'b0, PendCount}, 32'h0);
        check("iss0_busy1", {31'b0, Busy1}, 32'h0);

        // Issue x7 then x9
        IssueValid = 1'b1; IssueRd = 5'd7;
        step;
        IssueRd = 5'd9;
        step;
        IssueValid = 1'b0; A1 = 5'd7; A2 = 5'd9;
        #1;
        check("iss79_busy7", {31'b0, Busy1}, 32'h1);
        check("iss79_busy9", {31'b0, Busy2}, 32'h1);
        check("iss79_pendcount", {26'b0, PendCount}, 32'h2);

        // Writeback x7
        RegWrite = 1'b1; Rd = 5'd7; Result = 32'h0000_0077;
        #1;
        check("wb7_same_busy7", {31'b0, Busy1}, BYPASS ? 32'h0 : 32'h1);
        check("wb7_same_busy9", {31'b0, Busy2}, 32'h1);
        step;
        RegWrite = 1'b0;
        #1;
        check("wb7_busy7", {31'b0, Busy1}, 32'h0);
        check("wb7_busy9", {31'b0, Busy2}, 32'h1);
        check("wb7_pendcount", {26'b0, PendCount}, 32'h1);
        check("wb7_rd1", RD1, 32'h0000_0077);

        // Issue x3 and writeback x3 together: set wins
        IssueValid = 1'b1; IssueRd = 5'd3; RegWrite = 1'b1; Rd = 5'd3; Result = 32'h0000_0033;
        step;
        IssueValid = 1'b0; RegWrite = 1'b0; A1 = 5'd3; A2 = 5'd3;
        #1;
        check("same3_busy1", {31'b0, Busy1}, 32'h1);
        check("same3_busy2", {31'b0, Busy2}, 32'h1);
        check("same3_pendcount", {26'b0, PendCount}, 32'h2);
        check("same3_rd1", RD1, 32'h0000_0033);
        check("same3_rd2", RD2, 32'h0000_0033);

        // Issue x10 while writeback clears x9
        IssueValid = 1'b1; IssueRd = 5'd10; RegWrite = 1'b1; Rd = 5'd9; Result = 32'hA5A5_0009;
        step;
        IssueValid = 1'b0; RegWrite = 1'b0; A1 = 5'd9; A2 = 5'd10;
        #1;
        check("diff_busy9", {31'b0, Busy1}, 32'h0);
        check("diff_busy10", {31'b0, Busy2}, 32'h1);
        check("diff_pendcount", {26'b0, PendCount}, 32'h2);

        // Re-issue x10 does not double count
        IssueValid = 1'b1; IssueRd = 5'd10;
        step;
        IssueValid = 1'b0;
        #1;
        check("reiss_pendcount", {26'b0, PendCount}, 32'h2);

        // Set x1, x2, x4
        IssueValid = 1'b1; IssueRd = 5'd1;
        step;
        IssueRd = 5'd2;
        step;
        IssueRd = 5'd4;
        step;
        IssueValid = 1'b0;
        #1;
        check("pre_flush_pendcount", {26'b0, PendCount}, 32'h5);

        // Flush with issue to x6 and a redundant writeback to x2
        Flush = 1'b1; IssueValid = 1'b1; IssueRd = 5'd6; RegWrite = 1'b1; Rd = 5'd2; Result = 32'h0000_0222;
        step;
        Flush = 1'b0; IssueValid = 1'b0; RegWrite = 1'b0; A1 = 5'd6; A2 = 5'd1;
        #1;
        check("flush_pendcount", {26'b0, PendCount}, 32'h1);
        check("flush_busy6", {31'b0, Busy1}, 32'h1);
        check("flush_busy1", {31'b0, Busy2}, 32'h0);
        A1 = 5'd4; A2 = 5'd3;
        #1;
        check("flush_busy4", {31'b0, Busy1}, 32'h0);
        check("flush_busy3", {31'b0, Busy2}, 32'h0);
        A1 = 5'd2;
        #1;
        check("flush_rd2", RD1, 32'h0000_0222);

        // Asynchronous reset mid-sequence with traffic in flight
        IssueValid = 1'b1; IssueRd = 5'd12; RegWrite = 1'b1; Rd = 5'd8; Result = 32'h0808_0808;
        A1 = 5'd5; A2 = 5'd6;
        #1;
        rst = 1'b1;
        #1;
        check("async_rst_rd5", RD1, 32'h0);
        check("async_rst_busy6", {31'b0, Busy2}, 32'h0);
        check("async_rst_pendcount", {26'b0, PendCount}, 32'h0);
        step;
        @(negedge clk);
        rst = 1'b0; IssueValid = 1'b0; RegWrite = 1'b0; A1 = 5'd8; A2 = 5'd12;
        #1;
        check("post_rst_rd8", RD1, 32'h0);
        check("post_rst_busy12", {31'b0, Busy2}, 32'h0);
        check("post_rst_pendcount2", {26'b0, PendCount}, 32'h0);
        A1 = 5'd7; A2 = 5'd3;
        #1;
        check("post_rst_rd7", RD1, 32'h0);
        check("post_rst_rd3", RD2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
